// File: rtl/multi_channel_accumulator.sv
// Multi-channel signed accumulator with valid/ready sample input and an
// in-order drain stream of all channel totals.
// Optional build macro: ACC_SATURATE_EN (clamp on overflow instead of wrap).
module multi_channel_accumulator #(
    parameter int WIDTH          = 8,
    parameter int ACC_WIDTH      = 16,
    parameter int CHANNELS       = 4,
    parameter int CLEAR_ON_DRAIN = 1,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_chan,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sub,
    input  logic                 clear,
    input  logic                 drain_req,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_chan,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [CHANNELS-1:0]  ovf
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc [CHANNELS];
    logic [CW-1:0]        idx;

    logic [ACC_WIDTH-1:0] cur;
    logic                 chan_ok;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_hit;
    logic [ACC_WIDTH-1:0] res;
    logic [ACC_WIDTH-1:0] drain_val;

    // Select the addressed accumulator; out-of-range channels select nothing.
    always_comb begin
        cur     = '0;
        chan_ok = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (in_chan == CW'(c)) begin
                cur     = acc[c];
                chan_ok = 1'b1;
            end
        end
    end

    // Sign-extend, add/subtract one bit wider, detect and handle overflow.
    always_comb begin
        ext     = ACC_WIDTH'($signed(in_data));
        if (in_sub)
            sum = {cur[ACC_WIDTH-1], cur} - {ext[ACC_WIDTH-1], ext};
        else
            sum = {cur[ACC_WIDTH-1], cur} + {ext[ACC_WIDTH-1], ext};
        ovf_hit = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
`ifdef ACC_SATURATE_EN
        if (ovf_hit)
            res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            res = sum[ACC_WIDTH-1:0];
`else
        res = sum[ACC_WIDTH-1:0];
`endif
    end

    // Present the total of the channel currently being drained.
    always_comb begin
        drain_val = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (idx == CW'(c))
                drain_val = acc[c];
        end
    end

    assign out_data = drain_val;
    assign out_chan = idx;
    assign out_last = (idx == CW'(CHANNELS - 1));

    // Control FSM plus accumulator/flag storage with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++)
                acc[c] <= '0;
            ovf       <= '0;
            state     <= RUN;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (clear) begin
                        for (int unsigned c = 0; c < CHANNELS; c++)
                            acc[c] <= '0;
                        ovf <= '0;
                    end else begin
                        if (in_valid && in_ready && chan_ok) begin
                            for (int unsigned c = 0; c < CHANNELS; c++) begin
                                if (in_chan == CW'(c)) begin
                                    acc[c] <= res;
                                    if (ovf_hit)
                                        ovf[c] <= 1'b1;
                                end
                            end
                        end
                        if (drain_req) begin
                            state     <= DRAIN;
                            idx       <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (CLEAR_ON_DRAIN != 0) begin
                            for (int unsigned c = 0; c < CHANNELS; c++) begin
                                if (idx == CW'(c)) begin
                                    acc[c] <= '0;
                                    ovf[c] <= 1'b0;
                                end
                            end
                        end
                        if (out_last) begin
                            state     <= RUN;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Directed bench for multi_channel_accumulator: a default instance
// (4 channels, clear-on-drain) and a 3-channel persistent-total instance.
module tb_multi_channel_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, in_sub, clear, drain_req;
    logic [1:0]  in_chan;
    logic [7:0]  in_data;
    logic        busy, out_valid, out_ready, out_last;
    logic [1:0]  out_chan;
    logic [15:0] out_data;
    logic [3:0]  ovf;

    logic        in_valid3, in_ready3, in_sub3, clear3, drain_req3;
    logic [1:0]  in_chan3;
    logic [7:0]  in_data3;
    logic        busy3, out_valid3, out_ready3, out_last3;
    logic [1:0]  out_chan3;
    logic [15:0] out_data3;
    logic [2:0]  ovf3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_channel_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
        .in_data(in_data), .in_sub(in_sub), .clear(clear), .drain_req(drain_req),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_data(out_data), .out_last(out_last), .ovf(ovf)
    );

    multi_channel_accumulator #(.CHANNELS(3), .CLEAR_ON_DRAIN(0)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_chan(in_chan3),
        .in_data(in_data3), .in_sub(in_sub3), .clear(clear3), .drain_req(drain_req3),
        .busy(busy3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_chan(out_chan3), .out_data(out_data3), .out_last(out_last3), .ovf(ovf3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w16(input logic [15:0] v);
        return {16'b0, v};
    endfunction

    task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic sub);
        in_valid = 1'b1; in_chan = ch; in_data = d; in_sub = sub;
        tick();
        in_valid = 1'b0; in_sub = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic [7:0] d);
        in_valid3 = 1'b1; in_chan3 = ch; in_data3 = d;
        tick();
        in_valid3 = 1'b0;
    endtask

    task automatic drain4(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        out_ready = 1'b1;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0; in_valid = 1'b0; clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_busy"},  {31'b0, busy}, 32'd1);
            check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
            check({tag, "_chan"},  {30'b0, out_chan}, 32'(i));
            check({tag, "_data"},  w16(out_data), w16(16'(e[i])));
            check({tag, "_last"},  {31'b0, out_last}, {31'b0, i == 3});
            tick();
        end
        check({tag, "_end_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_end_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic drain3(input string tag, input int e0, input int e1, input int e2);
        int e [3];
        e = '{e0, e1, e2};
        out_ready3 = 1'b1;
        drain_req3 = 1'b1;
        tick();
        drain_req3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_valid"}, {31'b0, out_valid3}, 32'd1);
            check({tag, "_busy"},  {31'b0, busy3}, 32'd1);
            check({tag, "_chan"},  {30'b0, out_chan3}, 32'(i));
            check({tag, "_data"},  w16(out_data3), w16(16'(e[i])));
            check({tag, "_last"},  {31'b0, out_last3}, {31'b0, i == 2});
            tick();
        end
        check({tag, "_end_ready"}, {31'b0, in_ready3}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_chan = 0; in_data = 0; in_sub = 0; clear = 0; drain_req = 0; out_ready = 0;
        in_valid3 = 0; in_chan3 = 0; in_data3 = 0; in_sub3 = 0; clear3 = 0; drain_req3 = 0; out_ready3 = 0;
        tick();
        tick();
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ovf",       {28'b0, ovf}, 32'd0);
        check("rst_out_data",  w16(out_data), 32'd0);
        rst = 1'b0;

        // Basic accumulation, back-to-back samples, then drain and re-drain.
        send(2'd0, 8'd5, 1'b0);
        send(2'd0, 8'd3, 1'b0);
        send(2'd1, 8'hFC, 1'b0);
        send(2'd2, 8'd127, 1'b0);
        send(2'd3, 8'd1, 1'b1);
        drain4("basic", 8, -4, 127, -1);
        drain4("basic_zero", 0, 0, 0, 0);

        // Back-pressure on the ch1 beat.
        send(2'd0, 8'd1, 1'b0);
        send(2'd1, 8'd2, 1'b0);
        send(2'd2, 8'd3, 1'b0);
        send(2'd3, 8'd4, 1'b0);
        out_ready = 1'b1;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        check("bp_b0_data", w16(out_data), 32'd1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_chan",  {30'b0, out_chan}, 32'd1);
            check("bp_hold_data",  w16(out_data), 32'd2);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_last",  {31'b0, out_last}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_b2_chan", {30'b0, out_chan}, 32'd2);
        check("bp_b2_data", w16(out_data), 32'd3);
        tick();
        check("bp_b3_data", w16(out_data), 32'd4);
        check("bp_b3_last", {31'b0, out_last}, 32'd1);
        tick();
        check("bp_end_ready", {31'b0, in_ready}, 32'd1);

        // Overflow: 258 x 127 = 32766, one more pushes past +32767.
        in_valid = 1'b1; in_chan = 2'd0; in_data = 8'd127; in_sub = 1'b0;
        for (int i = 0; i < 259; i++)
            tick();
        in_valid = 1'b0;
        check("ovf_flags", {28'b0, ovf}, 32'h1);
`ifdef ACC_SATURATE_EN
        drain4("ovf", 32767, 0, 0, 0);
`else
        drain4("ovf", -32643, 0, 0, 0);
`endif
        check("ovf_cleared", {28'b0, ovf}, 32'h0);

        // Clear beats a same-cycle sample; drain includes a same-cycle sample.
        send(2'd2, 8'd7, 1'b0);
        clear = 1'b1;
        send(2'd2, 8'd5, 1'b0);
        clear = 1'b0;
        in_valid = 1'b1; in_chan = 2'd1; in_data = 8'd9; in_sub = 1'b0;
        drain4("simul", 0, 9, 0, 0);

        // Reset while presenting the ch2 beat.
        send(2'd0, 8'd10, 1'b0);
        send(2'd1, 8'd20, 1'b0);
        send(2'd2, 8'd30, 1'b0);
        send(2'd3, 8'd40, 1'b0);
        out_ready = 1'b1;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        tick();
        check("mid_chan", {30'b0, out_chan}, 32'd2);
        check("mid_data", w16(out_data), 32'd30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_busy",  {31'b0, busy}, 32'd0);
        drain4("mid_zero", 0, 0, 0, 0);

        // Three channels, totals persist across drains, channel 3 is discarded.
        send3(2'd1, 8'd10);
        drain3("keep1", 0, 10, 0);
        drain3("keep2", 0, 10, 0);
        send3(2'd3, 8'd50);
        drain3("keep3", 0, 10, 0);
        check("keep_ovf", {29'b0, ovf3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
